// File: rtl/dafx_adc_amplitude_monitor.sv
// -----------------------------------------------------------------------------
// dafx_adc_amplitude_monitor
//
// Watches the ADC sample stream that feeds the DAFX AXI register slave and
// produces three amplitude statistics:
//   * running signed min/max of every accepted sample since the last clear
//   * sustained-clipping detection (irq_0): CLIP_COUNT_P consecutive samples
//     whose saturating magnitude reaches the clip threshold
//   * per-window peak magnitude (sr_window_peak) with a window-done flag
//     (irq_1) every WINDOW_LENGTH_P accepted samples
// All outputs are registered; a sample accepted at edge N is visible after N.
//
// Ports
//   clk                       in   system clock
//   rst                       in   asynchronous reset, active high
//   adc_sample                in   signed ADC sample (two's complement)
//   adc_valid                 in   sample qualifier, always accepted
//   cr_clip_threshold         in   unsigned magnitude threshold
//   cmd_clear_adc_amplitude   in   pulse: restart min/max tracking
//   cmd_clear_irq_0           in   pulse: clear clip irq and clip counter
//   cmd_clear_irq_1           in   pulse: clear window irq
//   sr_cir_min_adc_amplitude  out  signed minimum since last clear
//   sr_cir_max_adc_amplitude  out  signed maximum since last clear
//   sr_window_peak            out  max |sample| of the last completed window
//   irq_0                     out  sticky: sustained clipping detected
//   irq_1                     out  sticky: peak window completed
// -----------------------------------------------------------------------------
module dafx_adc_amplitude_monitor #(
    parameter int AUDIO_WIDTH_P   = 24,
    parameter int CLIP_COUNT_P    = 4,
    parameter int WINDOW_LENGTH_P = 48000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AUDIO_WIDTH_P-1:0] adc_sample,
    input  logic                     adc_valid,
    input  logic [AUDIO_WIDTH_P-1:0] cr_clip_threshold,
    input  logic                     cmd_clear_adc_amplitude,
    input  logic                     cmd_clear_irq_0,
    input  logic                     cmd_clear_irq_1,
    output logic [AUDIO_WIDTH_P-1:0] sr_cir_min_adc_amplitude,
    output logic [AUDIO_WIDTH_P-1:0] sr_cir_max_adc_amplitude,
    output logic [AUDIO_WIDTH_P-1:0] sr_window_peak,
    output logic                     irq_0,
    output logic                     irq_1
);

    localparam int W          = AUDIO_WIDTH_P;
    localparam int CLIP_CNT_W = $clog2(CLIP_COUNT_P + 1);
    localparam int WIN_CNT_W  = $clog2(WINDOW_LENGTH_P);

    localparam logic [CLIP_CNT_W-1:0] CLIP_MAX  = CLIP_CNT_W'(CLIP_COUNT_P);
    localparam logic [CLIP_CNT_W-1:0] CLIP_LAST = CLIP_CNT_W'(CLIP_COUNT_P - 1);
    localparam logic [WIN_CNT_W-1:0]  WIN_LAST  = WIN_CNT_W'(WINDOW_LENGTH_P - 1);
    localparam logic [W-1:0]          MOST_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]          MOST_POS  = {1'b0, {(W-1){1'b1}}};

    typedef enum logic {
        WIN_FILL = 1'b0,
        WIN_DONE = 1'b1
    } win_state_e;

    // -------------------------------------------------------------------------
    // Saturating magnitude: the most negative code has no positive twin, so it
    // is clamped to the largest positive code instead of wrapping to itself.
    // -------------------------------------------------------------------------
    logic [W-1:0] mag;

    always_comb begin
        mag = adc_sample;
        if (adc_sample == MOST_NEG) begin
            mag = MOST_POS;
        end else if (adc_sample[W-1]) begin
            mag = ~adc_sample + W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Running min/max. A clear and a sample in the same cycle behave as
    // "clear, then load": the sample becomes both min and max.
    // -------------------------------------------------------------------------
    logic [W-1:0] min_q, min_d;
    logic [W-1:0] max_q, max_d;
    logic         empty_q, empty_d;
    logic         empty_eff;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        empty_eff = cmd_clear_adc_amplitude | empty_q;
        min_d     = cmd_clear_adc_amplitude ? '0 : min_q;
        max_d     = cmd_clear_adc_amplitude ? '0 : max_q;
        empty_d   = empty_eff;
        if (adc_valid) begin
            empty_d = 1'b0;
            if (empty_eff) begin
                min_d = adc_sample;
                max_d = adc_sample;
            end else begin
                if ($signed(adc_sample) < $signed(min_q)) min_d = adc_sample;
                if ($signed(adc_sample) > $signed(max_q)) max_d = adc_sample;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Clip counter. A clear zeroes the count before the same-cycle sample is
    // applied; irq_0 is set if the increment completes the run either from
    // the pre-clear count or from the cleared base, so set always wins.
    // -------------------------------------------------------------------------
    logic [CLIP_CNT_W-1:0] clip_cnt_q, clip_cnt_d;
    logic [CLIP_CNT_W-1:0] clip_base;
    logic                  clip_hit;
    logic                  irq_0_q, irq_0_d;

    always_comb begin
        clip_hit   = adc_valid && (mag >= cr_clip_threshold);
        clip_base  = cmd_clear_irq_0 ? '0 : clip_cnt_q;
        clip_cnt_d = clip_base;
        if (adc_valid) begin
            if (!clip_hit) begin
                clip_cnt_d = '0;
            end else if (clip_base != CLIP_MAX) begin
                clip_cnt_d = clip_base + 1'b1;
            end
        end
        irq_0_d = irq_0_q & ~cmd_clear_irq_0;
        if (clip_hit && ((clip_cnt_q == CLIP_LAST) || (clip_base == CLIP_LAST))) begin
            irq_0_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order of statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q      <= '0;
            max_q      <= '0;
            empty_q    <= 1'b1;
            clip_cnt_q <= '0;
            irq_0_q    <= 1'b0;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            empty_q    <= empty_d;
            clip_cnt_q <= clip_cnt_d;
            irq_0_q    <= irq_0_d;
        end
    end

    // -------------------------------------------------------------------------
    // Peak window FSM. Samples are accumulated in both states so no sample is
    // dropped; DONE only marks the cycle after a window completed.
    // -------------------------------------------------------------------------
    win_state_e           win_state_q;
    logic [WIN_CNT_W-1:0] win_cnt_q;
    logic [W-1:0]         win_acc_q;
    logic [W-1:0]         win_peak_q;
    logic                 irq_1_q;
    logic [W-1:0]         win_max;
    logic                 win_end;

    assign win_max = (mag > win_acc_q) ? mag : win_acc_q;
    assign win_end = adc_valid && (win_cnt_q == WIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_state_q <= WIN_FILL;
            win_cnt_q   <= '0;
            win_acc_q   <= '0;
            win_peak_q  <= '0;
            irq_1_q     <= 1'b0;
        end else begin
            if (adc_valid) begin
                if (win_end) begin
                    win_peak_q <= win_max;
                    win_acc_q  <= '0;
                    win_cnt_q  <= '0;
                end else begin
                    win_acc_q  <= win_max;
                    win_cnt_q  <= win_cnt_q + 1'b1;
                end
            end

            case (win_state_q)
                WIN_FILL: if (win_end) win_state_q <= WIN_DONE;
                WIN_DONE: win_state_q <= win_end ? WIN_DONE : WIN_FILL;
                default:  win_state_q <= WIN_FILL;
            endcase

            // Set wins over a same-cycle clear.
            if (win_end) begin
                irq_1_q <= 1'b1;
            end else if (cmd_clear_irq_1) begin
                irq_1_q <= 1'b0;
            end
        end
    end

    assign sr_cir_min_adc_amplitude = min_q;
    assign sr_cir_max_adc_amplitude = max_q;
    assign sr_window_peak           = win_peak_q;
    assign irq_0                    = irq_0_q;
    assign irq_1                    = irq_1_q;

endmodule

// File: tb/tb_dafx_adc_amplitude_monitor.sv
// -----------------------------------------------------------------------------
// tb_dafx_adc_amplitude_monitor
//
// Directed bench for dafx_adc_amplitude_monitor with CLIP_COUNT_P = 4 and
// WINDOW_LENGTH_P = 8. Inputs change on the falling edge, outputs are
// compared 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dafx_adc_amplitude_monitor;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] adc_sample;
    logic         adc_valid;
    logic [W-1:0] cr_clip_threshold;
    logic         cmd_clear_adc_amplitude;
    logic         cmd_clear_irq_0;
    logic         cmd_clear_irq_1;
    logic [W-1:0] sr_cir_min_adc_amplitude;
    logic [W-1:0] sr_cir_max_adc_amplitude;
    logic [W-1:0] sr_window_peak;
    logic         irq_0;
    logic         irq_1;

    int n_vec = 0;
    int n_err = 0;

    dafx_adc_amplitude_monitor #(
        .AUDIO_WIDTH_P  (W),
        .CLIP_COUNT_P   (4),
        .WINDOW_LENGTH_P(8)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .adc_sample              (adc_sample),
        .adc_valid               (adc_valid),
        .cr_clip_threshold       (cr_clip_threshold),
        .cmd_clear_adc_amplitude (cmd_clear_adc_amplitude),
        .cmd_clear_irq_0         (cmd_clear_irq_0),
        .cmd_clear_irq_1         (cmd_clear_irq_1),
        .sr_cir_min_adc_amplitude(sr_cir_min_adc_amplitude),
        .sr_cir_max_adc_amplitude(sr_cir_max_adc_amplitude),
        .sr_window_peak          (sr_window_peak),
        .irq_0                   (irq_0),
        .irq_1                   (irq_1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] s24(input int v);
        return v[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%06h) expected %0d (0x%06h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_minmax(input string tag, input int mn, input int mx);
        check({tag, ".min"}, sr_cir_min_adc_amplitude, s24(mn));
        check({tag, ".max"}, sr_cir_max_adc_amplitude, s24(mx));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".min"},  sr_cir_min_adc_amplitude, '0);
        check({tag, ".max"},  sr_cir_max_adc_amplitude, '0);
        check({tag, ".peak"}, sr_window_peak, '0);
        check({tag, ".irq0"}, W'(irq_0), '0);
        check({tag, ".irq1"}, W'(irq_1), '0);
    endtask

    // One clock cycle of stimulus; pulses are dropped after the edge.
    task automatic drive(input logic v, input int s, input logic clr_amp,
                         input logic clr0, input logic clr1);
        @(negedge clk);
        adc_valid               = v;
        adc_sample              = s24(s);
        cmd_clear_adc_amplitude = clr_amp;
        cmd_clear_irq_0         = clr0;
        cmd_clear_irq_1         = clr1;
        @(posedge clk);
        #1;
        adc_valid               = 1'b0;
        cmd_clear_adc_amplitude = 1'b0;
        cmd_clear_irq_0         = 1'b0;
        cmd_clear_irq_1         = 1'b0;
    endtask

    task automatic sample(input int s);
        drive(1'b1, s, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst                     = 1'b1;
        adc_sample              = '0;
        adc_valid               = 1'b0;
        cr_clip_threshold       = 24'hFFFFFF;
        cmd_clear_adc_amplitude = 1'b0;
        cmd_clear_irq_0         = 1'b0;
        cmd_clear_irq_1         = 1'b0;

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Test 1: running min/max
        sample(100);   check_minmax("t1.s0", 100, 100);
        sample(-50);   check_minmax("t1.s1", -50, 100);
        sample(300);   check_minmax("t1.s2", -50, 300);

        // Test 2: clear with/without a same-cycle sample
        drive(1'b1, 7, 1'b1, 1'b0, 1'b0);  check_minmax("t2.clr_load", 7, 7);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);  check_minmax("t2.clr_only", 0, 0);
        sample(-5);                        check_minmax("t2.first", -5, -5);

        // Test 3: clip run broken by a quiet sample, idle cycles hold the count
        pulse_reset();
        cr_clip_threshold = s24(1000);
        sample(1000);
        sample(-1200);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        sample(1500);  check("t3.irq0_run3", W'(irq_0), '0);
        sample(0);
        sample(1000);
        sample(1001);
        sample(-1001); check("t3.irq0_pre", W'(irq_0), '0);
        sample(2000);  check("t3.irq0_set", W'(irq_0), W'(1));
        check_minmax("t3", -1200, 2000);

        // Test 4: most-negative sample saturates to the threshold value
        pulse_reset();
        cr_clip_threshold = 24'h7FFFFF;
        sample(-8388608);
        sample(-8388608);
        sample(-8388608); check("t4.irq0_pre", W'(irq_0), '0);
        sample(-8388608); check("t4.irq0_set", W'(irq_0), W'(1));
        check_minmax("t4", -8388608, -8388608);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);  check("t4.irq0_clr", W'(irq_0), '0);
        sample(0);
        sample(-8388608);
        sample(-8388608);
        sample(-8388608);                  check("t4.irq0_run3", W'(irq_0), '0);
        drive(1'b1, -8388608, 1'b0, 1'b1, 1'b0);
        check("t4.set_wins", W'(irq_0), W'(1));
        // Count restarted at 1: two more hits bring it to 3, so a clear with a
        // fourth hit must set again.
        sample(-8388608);
        sample(-8388608);
        drive(1'b1, -8388608, 1'b0, 1'b1, 1'b0);
        check("t4.cnt_after_set", W'(irq_0), W'(1));

        // Test 5: peak windows of 8 samples
        pulse_reset();
        cr_clip_threshold = 24'hFFFFFF;
        sample(3);
        sample(-9);
        sample(4);
        sample(0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        sample(2);
        sample(8);
        sample(-1);    check("t5.irq1_pre", W'(irq_1), '0);
                       check("t5.peak_pre", sr_window_peak, '0);
        sample(5);     check("t5.irq1_set", W'(irq_1), W'(1));
                       check("t5.peak_w0", sr_window_peak, s24(9));
        check_minmax("t5.w0", -9, 8);
        sample(1);
        sample(1);
        sample(1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);  check("t5.irq1_clr", W'(irq_1), '0);
                                           check("t5.peak_hold", sr_window_peak, s24(9));
        sample(1);
        sample(1);
        sample(1);
        sample(1);
        drive(1'b1, 1, 1'b1, 1'b0, 1'b1);
        check("t5.set_wins", W'(irq_1), W'(1));
        check("t5.peak_w1", sr_window_peak, s24(1));
        check_minmax("t5.clr_at_end", 1, 1);

        // Test 6: asynchronous reset mid-window with irq_0 raised
        cr_clip_threshold = '0;
        for (int i = 0; i < 5; i++) sample(7);
        check("t6.irq0_pre", W'(irq_0), W'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("t6.async_rst");
        @(negedge clk);
        rst = 1'b0;
        sample(7);     check_minmax("t6.first", 7, 7);
        for (int i = 0; i < 6; i++) sample(7);
        check("t6.irq1_pre", W'(irq_1), '0);
        sample(7);     check("t6.irq1_set", W'(irq_1), W'(1));
                       check("t6.peak", sr_window_peak, s24(7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
